// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display block: FSM states,
// seven-segment codes and the per-nibble double-dabble correction.
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int          NUM_DIGITS   = 6;
  localparam int          SHIFT_CYCLES = 20;
  localparam logic [19:0] SCORE_MAX    = 20'd999999;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Add 3 to every nibble >= 5 so the following left shift carries correctly.
  function automatic logic [23:0] bcd_adjust(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// One seven-segment digit: 4-bit value plus blank request to active-low
// segments {dp,g,f,e,d,c,b,a}; dp stays off.
module hex_seg_decoder
  import score_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_code(digit);
  end

endmodule

// File: rtl/score_hex_display.sv
// Binary score to six seven-segment digits via a serial double-dabble FSM,
// with a one-deep pending slot for updates that arrive mid-conversion.
module score_hex_display
  import score_disp_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1,
  parameter int SCORE_W  = 20
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic               done,
  output logic [7:0]         HEX0,
  output logic [7:0]         HEX1,
  output logic [7:0]         HEX2,
  output logic [7:0]         HEX3,
  output logic [7:0]         HEX4,
  output logic [7:0]         HEX5,
  output logic [1:0]         dbg_state
);

  // score_valid is a strobe with no ready: in IDLE it starts a conversion,
  // otherwise it overwrites the pending slot (latest value wins).
  state_t       state_q, state_d;
  logic [19:0]  bin_q;
  logic [23:0]  bcd_q;
  logic [4:0]   cnt_q;
  logic [19:0]  pend_score_q;
  logic         pend_v_q;
  logic [23:0]  digits_q;
  logic         done_q;

  logic         load;
  logic [19:0]  load_raw;
  logic [19:0]  load_val;
  logic [43:0]  shift_pre;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (score_valid || pend_v_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 5'(SHIFT_CYCLES - 1)) state_d = LATCH;
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_raw  = score_valid ? score : pend_score_q;
    load_val  = (load_raw > SCORE_MAX) ? SCORE_MAX : load_raw;
    shift_pre = {bcd_adjust(bcd_q), bin_q};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_score_q <= '0;
      pend_v_q     <= 1'b0;
      digits_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == LATCH);
      if (load) begin
        bin_q    <= load_val;
        bcd_q    <= '0;
        cnt_q    <= '0;
        pend_v_q <= 1'b0;
      end
      if (state_q == SHIFT) begin
        {bcd_q, bin_q} <= {shift_pre[42:0], 1'b0};
        cnt_q          <= cnt_q + 5'd1;
      end
      if (state_q == LATCH) digits_q <= bcd_q;
      if (state_q != IDLE && score_valid) begin
        pend_v_q     <= 1'b1;
        pend_score_q <= score;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  // lz[k] is set when digit k and all more-significant digits are zero.
  logic [NUM_DIGITS:0]   lz;
  logic [NUM_DIGITS-1:0] blank;
  always_comb begin
    lz[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz[k] = lz[k+1] && (digits_q[k*4 +: 4] == 4'd0);
    end
    blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      blank[k] = BLANK_LZ && lz[k];
    end
  end

  logic [7:0] seg [NUM_DIGITS];
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decoder u_dec (
      .digit (digits_q[g*4 +: 4]),
      .blank (blank[g]),
      .seg   (seg[g])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];

endmodule

// File: tb/tb_score_hex_display.sv
// Bench for score_hex_display: a cycle-level countdown model of the
// conversion timing, per-cycle compare, and literal display expectations.
module tb_score_hex_display;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [19:0] score = '0;
  logic        score_valid = 1'b0;
  logic        busy, done;
  logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  score_hex_display #(.BLANK_LZ(1'b1), .SCORE_W(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .score(score), .score_valid(score_valid),
    .busy(busy), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .dbg_state(dbg_state)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input logic [19:0] v);
    return (int'(v) > 999999) ? 999999 : int'(v);
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int k);
    int p;
    int d;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 8'hFF;
    d = (v / p) % 10;
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  // Model: a conversion takes 21 edges from accept; during it a strobe goes
  // to a single pending slot; the display changes only when it completes.
  int          m_left = 0;
  int          m_val = 0;
  int          m_disp = 0;
  logic        m_pv = 1'b0;
  logic [19:0] m_pend = '0;
  logic        m_done = 1'b0;
  logic        model_on = 1'b0;
  int          cyc = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    m_done <= 1'b0;
    if (!Reset_n) begin
      m_left   <= 0;
      m_pv     <= 1'b0;
      m_disp   <= 0;
      model_on <= 1'b1;
    end else if (m_left == 0) begin
      if (score_valid) begin
        m_val <= clampi(score); m_left <= 21; m_pv <= 1'b0;
      end else if (m_pv) begin
        m_val <= clampi(m_pend); m_left <= 21; m_pv <= 1'b0;
      end
    end else begin
      if (score_valid) begin
        m_pv <= 1'b1; m_pend <= score;
      end
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_disp <= m_val; m_done <= 1'b1;
      end
    end
  end

  int         done_t[$];
  logic [7:0] done_h0[$];
  logic [7:0] hx [6];

  always @(negedge Clk) begin
    if (model_on) begin
      hx[0] = HEX0; hx[1] = HEX1; hx[2] = HEX2; hx[3] = HEX3; hx[4] = HEX4; hx[5] = HEX5;
      chk("busy", 64'(busy), 64'(m_left != 0));
      chk("done", 64'(done), 64'(m_done));
      for (int k = 0; k < 6; k++) chk($sformatf("HEX%0d", k), 64'(hx[k]), 64'(exp_seg(m_disp, k)));
      if (done === 1'b1) begin
        done_t.push_back(cyc);
        done_h0.push_back(HEX0);
      end
    end
  end

  function automatic logic [47:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  task automatic pulse(input logic [19:0] v);
    score = v;
    score_valid = 1'b1;
    @(posedge Clk);
    #1 score_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic convert(input string name, input logic [19:0] v, input logic [47:0] exp);
    int lat;
    pulse(v);
    wait_done(lat);
    chk({name, "_latency"}, 64'(lat), 64'd21);
    chk({name, "_hex"}, 64'(hex_all()), 64'(exp));
    idle(1);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int n0;
    int c0;

    Reset_n = 1'b0;
    idle(2);
    Reset_n = 1'b1;
    chk("reset_hex", 64'(hex_all()), 64'h0000_FFFF_FFFF_FFC0);
    chk("reset_busy", 64'(busy), 64'd0);

    // 123456 with explicit busy-length count
    pulse(20'd123456);
    busy_cnt = 1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("conv123456_latency", 64'(lat), 64'd21);
    chk("conv123456_busy_cycles", 64'(busy_cnt), 64'd21);
    chk("conv123456_hex", 64'(hex_all()), 64'h0000_F9A4_B099_9282);
    idle(1);

    convert("blank42", 20'd42, 48'hFFFF_FFFF_99A4);
    convert("zero", 20'd0, 48'hFFFF_FFFF_FFC0);
    convert("hundredk", 20'd100000, 48'hF9C0_C0C0_C0C0);
    convert("clamp_max", 20'd1048575, 48'h9090_9090_9090);
    convert("clamp_1m", 20'd1000000, 48'h9090_9090_9090);

    // pending slot: 5 at cycle 0, 7 at 3, 9 at 4
    n0 = done_t.size();
    pulse(20'd5);
    c0 = cyc;
    idle(2);
    pulse(20'd7);
    pulse(20'd9);
    idle(50);
    chk("pend_done_count", 64'(done_t.size() - n0), 64'd2);
    if (done_t.size() - n0 >= 2) begin
      chk("pend_first_time", 64'(done_t[n0] - c0), 64'd21);
      chk("pend_first_hex0", 64'(done_h0[n0]), 64'h92);
      chk("pend_second_time", 64'(done_t[n0+1] - c0), 64'd43);
      chk("pend_second_hex0", 64'(done_h0[n0+1]), 64'h90);
    end
    chk("pend_final_hex", 64'(hex_all()), 64'h0000_FFFF_FFFF_FF90);

    // reset mid-operation
    convert("show555", 20'd555, 48'hFFFF_FF92_9292);
    n0 = done_t.size();
    pulse(20'd888);
    idle(4);
    pulse(20'd111);
    idle(3);
    Reset_n = 1'b0;
    idle(1);
    Reset_n = 1'b1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_hex", 64'(hex_all()), 64'h0000_FFFF_FFFF_FFC0);
    idle(50);
    chk("midreset_no_done", 64'(done_t.size() - n0), 64'd0);
    chk("midreset_hex_after", 64'(hex_all()), 64'h0000_FFFF_FFFF_FFC0);

    // back-to-back: second strobe lands in the LATCH cycle
    n0 = done_t.size();
    pulse(20'd1234);
    idle(20);
    pulse(20'd4321);
    idle(30);
    chk("b2b_done_count", 64'(done_t.size() - n0), 64'd2);
    if (done_t.size() - n0 >= 2)
      chk("b2b_spacing", 64'(done_t[n0+1] - done_t[n0]), 64'd22);
    chk("b2b_hex", 64'(hex_all()), 64'h0000_FFFF_99B0_A4F9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
